// File: rtl/tb_simd_alu_pipe.sv
// Pipelined SIMD lane ALU (signed Q-bit lanes) with a valid/ready handshake and a transaction tag.
// Define TB_SAT_EN for saturating ADDS/SUBS/ABS/SELSIGN with per-lane sat flags; otherwise these ops wrap.
module tb_simd_alu_pipe #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned Q          = 8,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned TRANS_ID_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            op_i,
  input  logic [XLEN-1:0]       operand_a_i,
  input  logic [XLEN-1:0]       operand_b_i,
  input  logic [TRANS_ID_W-1:0] trans_id_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [XLEN-1:0]       result_o,
  output logic [TRANS_ID_W-1:0] trans_id_o,
  output logic [XLEN/Q-1:0]     sat_o
);

  localparam int unsigned LANES = XLEN / Q;

  typedef enum logic [3:0] {
    OP_MAX     = 4'd0,
    OP_MIN     = 4'd1,
    OP_SCALE   = 4'd2,
    OP_ADDSRL  = 4'd3,
    OP_SRL     = 4'd4,
    OP_ADDS    = 4'd5,
    OP_SUBS    = 4'd6,
    OP_SIGN    = 4'd7,
    OP_ABS     = 4'd8,
    OP_SELSIGN = 4'd9
  } op_e;

  logic [XLEN-1:0] lane_res;
  logic [Q-1:0]    la, lb, l_add, l_sub, l_abs, l_scl, l_negb, l_r;
  logic [Q:0]      l_sum;

`ifdef TB_SAT_EN
  localparam logic [Q-1:0] S_MIN = {1'b1, {(Q-1){1'b0}}};
  localparam logic [Q-1:0] S_MAX = {1'b0, {(Q-1){1'b1}}};
  logic [LANES-1:0] lane_sat;
  logic             l_ovf;
`endif

  always_comb begin
    lane_res = '0;
    la       = '0;
    lb       = '0;
    l_sum    = '0;
    l_add    = '0;
    l_sub    = '0;
    l_abs    = '0;
    l_scl    = '0;
    l_negb   = '0;
    l_r      = '0;
`ifdef TB_SAT_EN
    lane_sat = '0;
    l_ovf    = 1'b0;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
      la     = operand_a_i[i*Q +: Q];
      lb     = operand_b_i[i*Q +: Q];
      l_sum  = {la[Q-1], la} + {lb[Q-1], lb};
      l_add  = l_sum[Q-1:0];
      l_sub  = la - lb;
      // Unsigned magnitude: -2^(Q-1) maps to 2^(Q-1), exact when read unsigned.
      l_abs  = la[Q-1] ? -la : la;
      l_scl  = l_abs - (l_abs >> 2);
      l_negb = -lb;
      case (op_i)
        OP_MAX:     l_r = ($signed(la) > $signed(lb)) ? la : lb;
        OP_MIN:     l_r = ($signed(la) < $signed(lb)) ? la : lb;
        OP_SCALE:   l_r = la[Q-1] ? -l_scl : l_scl;
        OP_ADDSRL:  l_r = l_sum[Q:1];
        OP_SRL:     l_r = {la[Q-1], la[Q-1:1]};
        OP_ADDS:    l_r = l_add;
        OP_SUBS:    l_r = l_sub;
        OP_SIGN:    l_r = {{(Q-1){1'b0}}, la[Q-1]};
        OP_ABS:     l_r = l_abs;
        OP_SELSIGN: l_r = la[Q-1] ? l_negb : lb;
        default:    l_r = '0;
      endcase
`ifdef TB_SAT_EN
      case (op_i)
        OP_ADDS:    l_ovf = (la[Q-1] == lb[Q-1]) && (l_add[Q-1] != la[Q-1]);
        OP_SUBS:    l_ovf = (la[Q-1] != lb[Q-1]) && (l_sub[Q-1] != la[Q-1]);
        OP_ABS:     l_ovf = l_abs[Q-1];
        OP_SELSIGN: l_ovf = la[Q-1] && (lb == S_MIN);
        default:    l_ovf = 1'b0;
      endcase
      // Add/sub overflow direction follows the sign of a; ABS/SELSIGN only overflow upward.
      if (l_ovf)
        l_r = ((op_i == OP_ADDS || op_i == OP_SUBS) && la[Q-1]) ? S_MIN : S_MAX;
      lane_sat[i] = l_ovf;
`endif
      lane_res[i*Q +: Q] = l_r;
    end
  end

  logic [STAGES:1]                 vld_q, free;
  logic [STAGES:1][XLEN-1:0]       res_q;
  logic [STAGES:1][TRANS_ID_W-1:0] tag_q;
  logic                            accept;

  // free[k]: stage k may load this cycle (empty, or its content moves on).
  always_comb begin
    free         = '0;
    free[STAGES] = ~vld_q[STAGES] | ready_i;
    for (int unsigned k = STAGES - 1; k >= 1; k--)
      free[k] = ~vld_q[k] | free[k+1];
  end

  assign ready_o    = free[1];
  assign accept     = valid_i & free[1];
  assign valid_o    = vld_q[STAGES];
  assign result_o   = res_q[STAGES];
  assign trans_id_o = tag_q[STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      res_q <= '0;
      tag_q <= '0;
    end else begin
      if (flush_i) begin
        vld_q <= '0;
      end else begin
        if (free[1]) vld_q[1] <= valid_i;
        for (int unsigned k = 2; k <= STAGES; k++)
          if (free[k]) vld_q[k] <= vld_q[k-1];
      end
      if (accept) begin
        res_q[1] <= lane_res;
        tag_q[1] <= trans_id_i;
      end
      for (int unsigned k = 2; k <= STAGES; k++) begin
        if (free[k] && vld_q[k-1]) begin
          res_q[k] <= res_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

`ifdef TB_SAT_EN
  logic [STAGES:1][LANES-1:0] sat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_q <= '0;
    end else begin
      if (accept) sat_q[1] <= lane_sat;
      for (int unsigned k = 2; k <= STAGES; k++)
        if (free[k] && vld_q[k-1]) sat_q[k] <= sat_q[k-1];
    end
  end

  assign sat_o = sat_q[STAGES];
`else
  assign sat_o = '0;
`endif

endmodule

// File: doc/tb_simd_alu_pipe.md
Name: tb_simd_alu_pipe

Overview:
- Parametrised, pipelined SIMD lane ALU for turbo/polar decoder kernels; successor to the fixed 8x8 combinational turbo ops in the integer ALU.
- Operand width, lane width, pipeline depth and overflow policy are configurable.
- Sits beside the integer ALU as a separate functional unit, behind a valid/ready handshake, carrying a transaction ID through to writeback.

Parameters:
- XLEN, 64, operand/result width in bits.
- Q, 8, lane width in bits; XLEN % Q == 0, Q >= 4.
- LANES, XLEN/Q, lane count (derived; not overridable).
- STAGES, 2, pipeline register stages, range 1..4.
- TRANS_ID_W, 3, width of the transaction tag.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- flush_i  in  1  kill all in-flight operations.
- valid_i  in  1  input operation valid.
- ready_o  out  1  unit can accept an input this cycle.
- op_i  in  4  operation code (see Behaviour).
- operand_a_i  in  XLEN  packed lanes A, lane i = bits [i*Q +: Q].
- operand_b_i  in  XLEN  packed lanes B.
- trans_id_i  in  TRANS_ID_W  tag.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  packed lane results.
- trans_id_o  out  TRANS_ID_W  tag of result_o.
- sat_o  out  LANES  per-lane saturation flags for result_o (zero unless TB_SAT_EN is defined).

Behaviour:
- Ops, all lanes signed Q-bit:
  - 0 MAX: max(a, b).
  - 1 MIN: min(a, b).
  - 2 SCALE: sign(a)·(|a| − (|a|>>2)); |a| is computed in Q+1 bits, so a = −2^(Q−1) is exact.
  - 3 ADDSRL: (a + b) >>> 1 computed in Q+1 bits; never overflows.
  - 4 SRL: a >>> 1.
  - 5 ADDS: a + b.
  - 6 SUBS: a − b.
  - 7 SIGN: 1 if a < 0, else 0.
  - 8 ABS: |a|.
  - 9 SELSIGN: b if a ≥ 0, else −b.
  - 10–15: result 0, sat 0; the operation still flows through the pipe.
- Without saturation, ADDS, SUBS, ABS and SELSIGN wrap modulo 2^Q.
- Lane computation is combinational at stage 0 input; the result is registered at stage 1.
  - Stages 2..STAGES are pure delay registers carrying valid, result, tag and sat.
- Latency: exactly STAGES cycles from accepted input to valid_o when ready_i stays high; throughput 1 per cycle.
- Stage k advances when stage k+1 is empty or advancing; the last stage advances when valid_o & ready_i.
- ready_o = ~valid_stage1 | stage1_advances. This is a combinational path from ready_i, which is permitted.
- Input accepted on valid_i & ready_o.
- Stall: when valid_o & ~ready_i, result_o, trans_id_o and sat_o hold stable; no bubble is inserted and no data is lost.
- flush_i: all stage valid bits clear on the next edge and any input presented that cycle is dropped.
  - flush_i wins over simultaneous accept and output handshake.
  - Data registers need not clear.
- Reset (asynchronous, any time, including mid-operation):
  - valid_o = 0, ready_o = 1 (combinationally once valids are clear), result_o = 0, trans_id_o = 0, sat_o = 0.
  - All stage valids = 0.
- Data registers load only on stage advance (clock-gating friendly).

Optional Feature:
- Macro TB_SAT_EN.
- Defined:
  - ADDS, SUBS, ABS and SELSIGN clamp to [−2^(Q−1), 2^(Q−1)−1].
  - sat_o[i] = 1 when lane i clamped.
  - ABS(−128) = 127 and SELSIGN(−1, −128) = 127, each with sat set (Q=8).
- Undefined: wrap-around arithmetic; sat_o tied to 0 and no saturation logic is synthesised.

Test Plan:
- Q=8, STAGES=2, ADDS: a lanes all 0x70, b all 0x20, ready_i=1.
  - Without TB_SAT_EN: result 0x9090909090909090 at cycle +2, sat 0.
  - With TB_SAT_EN: 0x7F per lane, sat_o = 0xFF.
- SCALE: a = 0x80_7F_FC_04_00_01_FF_40 → lanes 0xA0, 0x60, 0xFD, 0x03, 0x00, 0x01, 0xFF, 0x30.
- ADDSRL: a = 0x7F, b = 0x7F → 0x7F; a = 0x80, b = 0x80 → 0x80; a = 0x03, b = 0xFE → 0x00.
- Back-to-back 4 ops with tags 0..3, ready_i low for 3 cycles after the first result.
  - The first result is held stable and ready_o drops once the pipe is full.
  - All four results emerge in order with matching tags; none lost or duplicated.
- flush_i pulsed with 2 ops in flight and valid_i high: no valid_o for those 3 ops; a new op accepted the next cycle completes with correct latency.
- rst_ni asserted asynchronously mid-stream with valid_o high: valid_o, result_o and sat_o go to 0 immediately, without waiting for a clock edge; after release, ready_o = 1 and normal operation resumes.
